instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Program store and sequencer for the Tiny CPU, directly upstream of the instruction decoder. It holds a small 4-bit program memory loaded over a valid/ready stream. On Start it plays the program out, one instruction per cycle, on a registered `Instruction` bus that drives the decoder's `instruction` input. It automatically issues a leading Clear instruction and supports pause, halt and looping.

## Interface
Parameters:
- `AW`, 4: program address width; memory depth `DEPTH = 2**AW`.

Ports:
- `Clock` in 1: single clock, all logic on rising edge.
- `Reset` in 1: synchronous, active-high.
- `LoadStart` in 1: pulse in IDLE; begins a program load at address 0.
- `LoadValid` in 1: `LoadData` valid this cycle.
- `LoadData` in 4: instruction word to store.
- `LoadEnd` in 1: pulse in LOAD; terminates the load.
- `LoadReady` out 1: high in LOAD while memory not full.
- `Start` in 1: pulse in IDLE; begins execution.
- `Pause` in 1: level; freezes execution while high.
- `Halt` in 1: aborts execution.
- `Loop` in 1: level, sampled at the last instruction; 1 = wrap to address 0.
- `Instruction` out 4: registered, to the decoder.
- `InstrValid` out 1: `Instruction` is a real program word or the leading Clear.
- `PC` out AW: address of the word currently on `Instruction`.
- `ProgLength` out AW+1: number of stored words, range 0..DEPTH.
- `Busy` out 1: high in CLEAR/RUN.
- `Done` out 1: one-cycle pulse at normal completion.

## Operation
- NOP encoding is 4'b1111; the decoder drives all enables to 0 for it. `Instruction` = NOP and `InstrValid` = 0 whenever nothing is issued.
- States: IDLE, LOAD, CLEAR, RUN.
- IDLE:
  - `LoadStart` → LOAD, with write pointer `wptr` = 0.
  - `Start` with `ProgLength` > 0 → CLEAR.
  - `Start` with `ProgLength` = 0 is ignored.
  - `LoadStart` and `Start` in the same cycle: `LoadStart` wins.
- LOAD:
  - `LoadReady` = (`wptr` < DEPTH).
  - A handshake (`LoadValid` & `LoadReady`) writes `mem[wptr]` = `LoadData` and increments `wptr`.
  - `LoadEnd` → IDLE with `ProgLength` = `wptr`. This value includes any word handshaken in the same cycle as `LoadEnd`.
  - When `wptr` reaches DEPTH: automatic → IDLE with `ProgLength` = DEPTH.
  - `Start`, `Halt` and `Pause` are ignored in LOAD.
- CLEAR: issues `Instruction` = 4'b0000 with `InstrValid` = 1 for exactly one cycle, then → RUN with `PC` = 0. `Pause` does not delay CLEAR. `Halt` aborts it.
- RUN: each unpaused cycle issues `mem[PC]` with `InstrValid` = 1.
  - After the word at `PC` = `ProgLength`−1 is issued, with `Loop` = 1: next `PC` = 0, stay in RUN.
  - Otherwise: → IDLE, with `Done` = 1 for one cycle.
- Pause, in RUN: `Instruction` = NOP, `InstrValid` = 0, `PC` held. The issued sequence resumes at the held `PC` with no word skipped or repeated.
- Halt, in CLEAR or RUN: next cycle is IDLE with NOP, `InstrValid` = 0, and no `Done`.
- Priority in RUN: `Halt` > `Pause` > advance.
- `PC` is AW bits and wraps naturally. `ProgLength` is AW+1 bits so that DEPTH is representable.
- Memory contents are not cleared by reset. `ProgLength` = 0 makes stale contents unreachable.

## Timing
- Reset values:
  - state = IDLE, `wptr` = 0, `PC` = 0, `ProgLength` = 0.
  - `Instruction` = 4'b1111, `InstrValid` = 0.
  - `LoadReady` = 0, `Busy` = 0, `Done` = 0.
- Reset mid-load or mid-run: same values on the next cycle. Any partial load is discarded because `ProgLength` = 0.
- All outputs are registered.
- `Start` sampled at edge t:
  - CLEAR word (0000) visible t+1.
  - `mem[0]` visible t+2.
  - `mem[k]` visible t+2+k, absent pauses.
- `Done` is high in the cycle after the last word is visible. `Busy` drops in that same cycle.
- `LoadReady` rises the cycle after `LoadStart`.
- Pause or Halt sampled at edge t takes effect in the output visible at t+1.
- `Start` is accepted again the cycle after `Done`.

## Test plan
- Load and run:
  - Stimulus: load 4'b0001, 4'b0010, 4'b0100, then `LoadEnd`; then `Start`.
  - Required: `ProgLength` = 3; `Instruction` sequence 0000, 0001, 0010, 0100, then NOP.
  - Required: `PC` = 0, 1, 2 on the three program words; `Done` pulse on the cycle the NOP appears.
- Full memory:
  - Stimulus: stream 17 words with `LoadValid` held high.
  - Required: 16 handshakes, `LoadReady` = 0 after the 16th, `ProgLength` = 16, auto-return to IDLE.
  - Required: running the program issues 16 words with `PC` wrapping 15 → done.
- Pause:
  - Stimulus: 3-word program; assert `Pause` for 2 cycles after `mem[0]` is issued.
  - Required: two NOP cycles with `PC` held at 0, then `mem[1]`, `mem[2]`, `Done`.
- Loop and Halt:
  - Stimulus: `Loop` = 1 with a 2-word program; assert `Halt` after 5 issued words.
  - Required: words issued as w0, w1, w0, w1, w0; NOP next; no `Done`; `Busy` = 0.
- Edge starts:
  - Stimulus: `Start` with `ProgLength` = 0.
  - Required: stays IDLE, no CLEAR issued.
  - Stimulus: `LoadStart` and `Start` in the same cycle.
  - Required: LOAD entered.
  - Stimulus: `Reset` during RUN.
  - Required: all outputs at reset values on the next cycle, and a subsequent `Start` is ignored.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Program store and sequencer for the Tiny CPU: loads a small program over a
// valid/ready stream and plays it out, one word per cycle, after a leading Clear.
module instruction_sequencer #(
    parameter int AW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          LoadStart,
    input  logic          LoadValid,
    input  logic [3:0]    LoadData,
    input  logic          LoadEnd,
    output logic          LoadReady,
    input  logic          Start,
    input  logic          Pause,
    input  logic          Halt,
    input  logic          Loop,
    output logic [3:0]    Instruction,
    output logic          InstrValid,
    output logic [AW-1:0] PC,
    output logic [AW:0]   ProgLength,
    output logic          Busy,
    output logic          Done
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];
    localparam logic [AW:0] C_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [3:0]  C_NOP   = 4'b1111;
    localparam logic [3:0]  C_CLEAR = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CLEAR = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_mem [DEPTH];
    logic [AW:0]   r_wptr, w_wptr_nxt, w_wptr_inc;
    logic [AW:0]   r_len, w_len_nxt;
    // r_next is the address to issue next; r_pc is the address last shown.
    logic [AW-1:0] r_next, w_next_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic          r_end, w_end_nxt;
    logic [3:0]    r_instr, w_instr_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_ready, w_ready_nxt;
    logic          w_hs, w_we, w_last;

    assign w_hs       = LoadValid & r_ready;
    assign w_wptr_inc = r_wptr + {{AW{1'b0}}, w_hs};
    assign w_last     = ({1'b0, r_next} == (r_len - C_ONE));

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_len_nxt   = r_len;
        w_next_nxt  = r_next;
        w_pc_nxt    = r_pc;
        w_end_nxt   = r_end;
        w_instr_nxt = C_NOP;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (LoadStart) begin
                    w_state_nxt = S_LOAD;
                    w_wptr_nxt  = {(AW+1){1'b0}};
                end else if (Start && (r_len != {(AW+1){1'b0}})) begin
                    w_state_nxt = S_CLEAR;
                    w_instr_nxt = C_CLEAR;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = {AW{1'b0}};
                    w_next_nxt  = {AW{1'b0}};
                    w_end_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                w_we       = w_hs;
                w_wptr_nxt = w_wptr_inc;
                // A word handshaken alongside LoadEnd still counts.
                if (LoadEnd) begin
                    w_state_nxt = S_IDLE;
                    w_len_nxt   = w_wptr_inc;
                end else if (w_wptr_inc == C_DEPTH) begin
                    w_state_nxt = S_IDLE;
                    w_len_nxt   = C_DEPTH;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_CLEAR, S_RUN: begin
                if (Halt) begin
                    w_state_nxt = S_IDLE;
                end else if (Pause) begin
                    w_state_nxt = S_RUN;
                end else if (r_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                    w_instr_nxt = r_mem[r_next];
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_next;
                    if (!w_last) begin
                        w_next_nxt = r_next + {{(AW-1){1'b0}}, 1'b1};
                    end else if (Loop) begin
                        w_next_nxt = {AW{1'b0}};
                    end else begin
                        w_end_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt  = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_RUN);
        w_ready_nxt = (w_state_nxt == S_LOAD) && (w_wptr_nxt < C_DEPTH);
    end

    // State and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_wptr  <= {(AW+1){1'b0}};
            r_len   <= {(AW+1){1'b0}};
            r_next  <= {AW{1'b0}};
            r_pc    <= {AW{1'b0}};
            r_end   <= 1'b0;
            r_instr <= C_NOP;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
            r_len   <= w_len_nxt;
            r_next  <= w_next_nxt;
            r_pc    <= w_pc_nxt;
            r_end   <= w_end_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Program memory; deliberately not reset, ProgLength gates reachability.
    always_ff @(posedge Clock) begin
        if (w_we) begin
            r_mem[r_wptr[AW-1:0]] <= LoadData;
        end
    end

    assign LoadReady   = r_ready;
    assign Instruction = r_instr;
    assign InstrValid  = r_valid;
    assign PC          = r_pc;
    assign ProgLength  = r_len;
    assign Busy        = r_busy;
    assign Done        = r_done;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer.
module tb_instruction_sequencer;

    logic       Clock = 1'b0;
    logic       Reset, LoadStart, LoadValid, LoadEnd, Start, Pause, Halt, Loop;
    logic [3:0] LoadData;
    logic       LoadReady, InstrValid, Busy, Done;
    logic [3:0] Instruction;
    logic [3:0] PC;
    logic [4:0] ProgLength;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_hs;
    logic [3:0] word;

    instruction_sequencer #(.AW(4)) dut (
        .Clock(Clock), .Reset(Reset), .LoadStart(LoadStart), .LoadValid(LoadValid),
        .LoadData(LoadData), .LoadEnd(LoadEnd), .LoadReady(LoadReady), .Start(Start),
        .Pause(Pause), .Halt(Halt), .Loop(Loop), .Instruction(Instruction),
        .InstrValid(InstrValid), .PC(PC), .ProgLength(ProgLength), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issued word: instruction, valid, pc together.
    task automatic check_word(input string tag, input logic [3:0] w, input logic [3:0] pc);
        check({tag, ".instr"}, 32'(Instruction), 32'(w));
        check({tag, ".valid"}, 32'(InstrValid), 32'd1);
        check({tag, ".pc"}, 32'(PC), 32'(pc));
    endtask

    task automatic check_nop(input string tag);
        check({tag, ".instr"}, 32'(Instruction), 32'hF);
        check({tag, ".valid"}, 32'(InstrValid), 32'd0);
    endtask

    task automatic load_words(input int n, input logic [15:0] words);
        LoadStart = 1'b1;
        tick();
        LoadStart = 1'b0;
        for (int k = 0; k < n; k++) begin
            LoadValid = 1'b1;
            LoadData  = words[4*k +: 4];
            LoadEnd   = (k == n - 1);
            tick();
        end
        LoadValid = 1'b0;
        LoadEnd   = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; LoadStart = 1'b0; LoadValid = 1'b0; LoadEnd = 1'b0; LoadData = 4'd0;
        Start = 1'b0; Pause = 1'b0; Halt = 1'b0; Loop = 1'b0;
        tick(); tick();
        check_nop("reset");
        check("reset.pc", 32'(PC), 32'd0);
        check("reset.len", 32'(ProgLength), 32'd0);
        check("reset.ready", 32'(LoadReady), 32'd0);
        check("reset.busy", 32'(Busy), 32'd0);
        check("reset.done", 32'(Done), 32'd0);
        Reset = 1'b0;

        // Start with an empty program is ignored.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check_nop("empty_start");
        check("empty_start.busy", 32'(Busy), 32'd0);
        tick();
        check_nop("empty_start2");

        // LoadStart wins over Start, then load 0001,0010,0100.
        LoadStart = 1'b1; Start = 1'b1;
        tick();
        LoadStart = 1'b0; Start = 1'b0;
        check("both.ready", 32'(LoadReady), 32'd1);
        check("both.busy", 32'(Busy), 32'd0);
        check_nop("both");
        LoadValid = 1'b1; LoadData = 4'b0001; tick();
        LoadData = 4'b0010; tick();
        LoadData = 4'b0100; LoadEnd = 1'b1; tick();
        LoadValid = 1'b0; LoadEnd = 1'b0;
        check("load3.len", 32'(ProgLength), 32'd3);
        check("load3.ready", 32'(LoadReady), 32'd0);

        Start = 1'b1; tick(); Start = 1'b0;
        check("run3.clear.instr", 32'(Instruction), 32'h0);
        check("run3.clear.valid", 32'(InstrValid), 32'd1);
        check("run3.clear.busy", 32'(Busy), 32'd1);
        tick(); check_word("run3.w0", 4'b0001, 4'd0);
        tick(); check_word("run3.w1", 4'b0010, 4'd1);
        check("run3.done_early", 32'(Done), 32'd0);
        tick(); check_word("run3.w2", 4'b0100, 4'd2);
        tick(); check_nop("run3.end");
        check("run3.done", 32'(Done), 32'd1);
        check("run3.busy", 32'(Busy), 32'd0);
        tick();
        check("run3.done_pulse", 32'(Done), 32'd0);

        // Full memory: 17 words streamed, only 16 accepted.
        LoadStart = 1'b1; tick(); LoadStart = 1'b0;
        n_hs = 0;
        LoadValid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            LoadData = 4'(i * 7 + 3);
            if (LoadReady) n_hs++;
            tick();
        end
        LoadValid = 1'b0;
        check("full.handshakes", 32'(n_hs), 32'd16);
        check("full.ready", 32'(LoadReady), 32'd0);
        check("full.len", 32'(ProgLength), 32'd16);
        Start = 1'b1; tick(); Start = 1'b0;
        check("full.clear.instr", 32'(Instruction), 32'h0);
        for (int i = 0; i < 16; i++) begin
            tick();
            word = 4'(i * 7 + 3);
            check_word($sformatf("full.w%0d", i), word, 4'(i));
        end
        tick();
        check_nop("full.end");
        check("full.done", 32'(Done), 32'd1);

        // Pause for two cycles after mem[0].
        load_words(3, 16'h035A);
        check("pause.len", 32'(ProgLength), 32'd3);
        Start = 1'b1; tick(); Start = 1'b0;
        tick(); check_word("pause.w0", 4'hA, 4'd0);
        Pause = 1'b1;
        tick(); check_nop("pause.p1");
        check("pause.p1.pc", 32'(PC), 32'd0);
        check("pause.p1.busy", 32'(Busy), 32'd1);
        tick(); check_nop("pause.p2");
        check("pause.p2.pc", 32'(PC), 32'd0);
        Pause = 1'b0;
        tick(); check_word("pause.w1", 4'h5, 4'd1);
        tick(); check_word("pause.w2", 4'h3, 4'd2);
        tick(); check_nop("pause.end");
        check("pause.done", 32'(Done), 32'd1);

        // Loop a 2-word program, halt after five issued words.
        load_words(2, 16'h006C);
        Loop = 1'b1;
        Start = 1'b1; tick(); Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            word = (i % 2 == 0) ? 4'hC : 4'h6;
            check_word($sformatf("loop.w%0d", i), word, 4'(i % 2));
        end
        Halt = 1'b1; tick(); Halt = 1'b0; Loop = 1'b0;
        check_nop("halt");
        check("halt.busy", 32'(Busy), 32'd0);
        check("halt.done", 32'(Done), 32'd0);
        tick();
        check("halt.done2", 32'(Done), 32'd0);

        // Reset during RUN, then Start must be ignored.
        Start = 1'b1; tick(); Start = 1'b0;
        tick(); check_word("rst.w0", 4'hC, 4'd0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        check_nop("rst");
        check("rst.pc", 32'(PC), 32'd0);
        check("rst.len", 32'(ProgLength), 32'd0);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.ready", 32'(LoadReady), 32'd0);
        Start = 1'b1; tick(); Start = 1'b0;
        check_nop("rst.start");
        check("rst.start.busy", 32'(Busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
